// File: rtl/cursor_overlay_if.sv
// Video pixel stream bundle for the cursor overlay: raster/background in, composited pixel out.
interface cursor_overlay_if #(
  parameter int unsigned CRD_W   = 11,
  parameter int unsigned COLOR_W = 12
);
  logic               frame_start;
  logic               in_valid;
  logic [CRD_W-1:0]   hcount;
  logic [CRD_W-1:0]   vcount;
  logic [COLOR_W-1:0] rgb_in;
  logic               out_valid;
  logic [COLOR_W-1:0] rgb_out;
  logic               cursor_hit;

  modport master (
    output frame_start, in_valid, hcount, vcount, rgb_in,
    input  out_valid, rgb_out, cursor_hit
  );

  modport slave (
    input  frame_start, in_valid, hcount, vcount, rgb_in,
    output out_valid, rgb_out, cursor_hit
  );
endinterface

// File: rtl/cursor_overlay.sv
// Composites a 16x16 ROM cursor bitmap over the raster stream with a fixed 2-clock latency.
// Cursor position/enable are latched per frame so the cursor never tears mid-frame.
module cursor_overlay #(
  parameter int unsigned        CRD_W            = 11,
  parameter int unsigned        COLOR_W          = 12,
  parameter int unsigned        H_ACTIVE         = 640,
  parameter int unsigned        V_ACTIVE         = 480,
  parameter logic [COLOR_W-1:0] CONTOUR_COLOR    = 12'h000,
  parameter logic [COLOR_W-1:0] FILL_COLOR       = 12'hFFF,
  parameter bit                 FILL_TRANSPARENT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cursor_en,
  input  logic              pos_valid,
  input  logic [CRD_W-1:0]  pos_x,
  input  logic [CRD_W-1:0]  pos_y,
  cursor_overlay_if.slave   vid,
  output logic [3:0]        rom_x,
  output logic [3:0]        rom_y,
  input  logic [1:0]        rom_data
);

  typedef enum logic [1:0] {
    PX_CLEAR   = 2'b00,
    PX_CONTOUR = 2'b01,
    PX_FILL    = 2'b10,
    PX_RSVD    = 2'b11
  } px_code_e;

  localparam logic [CRD_W-1:0] X_MAX = CRD_W'(H_ACTIVE - 1);
  localparam logic [CRD_W-1:0] Y_MAX = CRD_W'(V_ACTIVE - 1);
  localparam logic [CRD_W:0]   WIN   = (CRD_W+1)'(16);

  logic [CRD_W-1:0]   pend_x_q, pend_y_q;
  logic [CRD_W-1:0]   act_x_q, act_y_q;
  logic               act_en_q, dirty_q;
  logic               valid1_q, hit1_q;
  logic [COLOR_W-1:0] rgb1_q;
  logic               out_valid_q, cursor_hit_q;
  logic [COLOR_W-1:0] rgb_out_q, rgb_out_d;

  logic [CRD_W-1:0]   clamp_x, clamp_y;
  logic [CRD_W:0]     hx, vy, ax, ay;
  logic [3:0]         dx, dy;
  logic               hit0;

  always_comb begin
    clamp_x = (pos_x > X_MAX) ? X_MAX : pos_x;
    clamp_y = (pos_y > Y_MAX) ? Y_MAX : pos_y;
    // One extra bit so the window's right/bottom edge never wraps near the clamp limit
    hx   = {1'b0, vid.hcount};
    vy   = {1'b0, vid.vcount};
    ax   = {1'b0, act_x_q};
    ay   = {1'b0, act_y_q};
    hit0 = act_en_q & vid.in_valid &
           (hx >= ax) & (hx < ax + WIN) &
           (vy >= ay) & (vy < ay + WIN);
    dx    = vid.hcount[3:0] - act_x_q[3:0];
    dy    = vid.vcount[3:0] - act_y_q[3:0];
    rom_x = hit0 ? dx : '0;
    rom_y = hit0 ? dy : '0;
  end

  always_comb begin
    rgb_out_d = rgb1_q;
    if (hit1_q) begin
      unique case (px_code_e'(rom_data))
        PX_CONTOUR: rgb_out_d = CONTOUR_COLOR;
        PX_FILL:    rgb_out_d = FILL_TRANSPARENT ? rgb1_q : FILL_COLOR;
        PX_CLEAR,
        PX_RSVD:    rgb_out_d = rgb1_q;
      endcase
    end
    if (!valid1_q) rgb_out_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      act_en_q     <= 1'b0;
      dirty_q      <= 1'b0;
      valid1_q     <= 1'b0;
      hit1_q       <= 1'b0;
      rgb1_q       <= '0;
      out_valid_q  <= 1'b0;
      cursor_hit_q <= 1'b0;
      rgb_out_q    <= '0;
    end else begin
      if (pos_valid) begin
        pend_x_q <= clamp_x;
        pend_y_q <= clamp_y;
      end
      // A position arriving with frame_start bypasses pending and applies this frame
      if (vid.frame_start) begin
        act_en_q <= cursor_en;
        dirty_q  <= 1'b0;
        if (pos_valid) begin
          act_x_q <= clamp_x;
          act_y_q <= clamp_y;
        end else if (dirty_q) begin
          act_x_q <= pend_x_q;
          act_y_q <= pend_y_q;
        end
      end else if (pos_valid) begin
        dirty_q <= 1'b1;
      end
      valid1_q     <= vid.in_valid;
      hit1_q       <= hit0;
      rgb1_q       <= vid.rgb_in;
      out_valid_q  <= valid1_q;
      cursor_hit_q <= hit1_q & valid1_q;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign vid.out_valid  = out_valid_q;
  assign vid.cursor_hit = cursor_hit_q;
  assign vid.rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_cursor_overlay.sv
// Bench for cursor_overlay: opaque-fill and transparent-fill instances driven in lockstep,
// checked every cycle against a geometric model, plus literal pixel expectations.
module tb_cursor_overlay;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cursor_en = 1'b0, pos_valid = 1'b0;
  logic [10:0] pos_x = '0, pos_y = '0;
  logic        frame_start = 1'b0, in_valid = 1'b0;
  logic [10:0] hcount = '0, vcount = '0;
  logic [11:0] rgb_in = 12'hABC;
  logic        pin_en = 1'b0;
  logic [11:0] pin_val = '0, pin_tval = '0;

  logic [3:0]  rom_x0, rom_y0, rom_x1, rom_y1;
  logic [1:0]  rom_d0, rom_d1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cursor_overlay_if #(.CRD_W(11), .COLOR_W(12)) vif0 ();
  cursor_overlay_if #(.CRD_W(11), .COLOR_W(12)) vif1 ();

  assign vif0.frame_start = frame_start;
  assign vif0.in_valid    = in_valid;
  assign vif0.hcount      = hcount;
  assign vif0.vcount      = vcount;
  assign vif0.rgb_in      = rgb_in;
  assign vif1.frame_start = frame_start;
  assign vif1.in_valid    = in_valid;
  assign vif1.hcount      = hcount;
  assign vif1.vcount      = vcount;
  assign vif1.rgb_in      = rgb_in;

  cursor_overlay #(.CRD_W(11), .COLOR_W(12), .H_ACTIVE(640), .V_ACTIVE(480),
                   .CONTOUR_COLOR(12'h000), .FILL_COLOR(12'hFFF), .FILL_TRANSPARENT(1'b0)) dut (
    .clk(clk), .rst(rst), .cursor_en(cursor_en), .pos_valid(pos_valid),
    .pos_x(pos_x), .pos_y(pos_y), .vid(vif0.slave),
    .rom_x(rom_x0), .rom_y(rom_y0), .rom_data(rom_d0));

  cursor_overlay #(.CRD_W(11), .COLOR_W(12), .H_ACTIVE(640), .V_ACTIVE(480),
                   .CONTOUR_COLOR(12'h000), .FILL_COLOR(12'hFFF), .FILL_TRANSPARENT(1'b1)) dut_t (
    .clk(clk), .rst(rst), .cursor_en(cursor_en), .pos_valid(pos_valid),
    .pos_x(pos_x), .pos_y(pos_y), .vid(vif1.slave),
    .rom_x(rom_x1), .rom_y(rom_y1), .rom_data(rom_d1));

  // Bitmap: contour border (top row partly clear), fill interior, bottom row reserved code
  function automatic logic [1:0] bmp(int x, int y);
    if (y == 0)  return (x < 12) ? 2'b01 : 2'b00;
    if (y == 15) return 2'b11;
    if (x == 0 || x == 15) return 2'b01;
    return 2'b10;
  endfunction

  always @(posedge clk) begin
    rom_d0 <= bmp(int'(rom_x0), int'(rom_y0));
    rom_d1 <= bmp(int'(rom_x1), int'(rom_y1));
  end

  function automatic logic [11:0] colour(logic [1:0] code, bit transp, logic [11:0] bg);
    case (code)
      2'b01:   return 12'h000;
      2'b10:   return transp ? bg : 12'hFFF;
      default: return bg;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v; logic hit; logic [11:0] rgb; logic [11:0] rgbt;
    logic pe; logic [11:0] pv; logic [11:0] ptv;
  } exp_t;

  exp_t e1, e2;
  int   m_px, m_py, m_ax, m_ay;
  bit   m_en, m_dirty;

  function automatic bit in_win(int h, int v);
    return m_en && (h >= m_ax) && (h < m_ax + 16) && (v >= m_ay) && (v < m_ay + 16);
  endfunction

  initial begin
    e1 = '{default: '0};
    e2 = '{default: '0};
    m_px = 0; m_py = 0; m_ax = 0; m_ay = 0; m_en = 0; m_dirty = 0;
  end

  always @(posedge clk) begin
    int h, v, cx, cy;
    bit hit;
    logic [1:0] code;
    h = int'(hcount);
    v = int'(vcount);
    if (rst) begin
      e1 = '{default: '0};
      e2 = '{default: '0};
      m_px = 0; m_py = 0; m_ax = 0; m_ay = 0; m_en = 0; m_dirty = 0;
    end else begin
      e2 = e1;
      hit  = in_valid && in_win(h, v);
      code = hit ? bmp(h - m_ax, v - m_ay) : 2'b00;
      e1.v    = in_valid;
      e1.hit  = hit;
      e1.rgb  = !in_valid ? 12'h000 : colour(code, 1'b0, rgb_in);
      e1.rgbt = !in_valid ? 12'h000 : colour(code, 1'b1, rgb_in);
      e1.pe   = pin_en;
      e1.pv   = pin_val;
      e1.ptv  = pin_tval;
      cx = (int'(pos_x) > 639) ? 639 : int'(pos_x);
      cy = (int'(pos_y) > 479) ? 479 : int'(pos_y);
      if (frame_start) begin
        m_en = cursor_en;
        if (pos_valid) begin m_ax = cx; m_ay = cy; end
        else if (m_dirty) begin m_ax = m_px; m_ay = m_py; end
        m_dirty = 0;
      end else if (pos_valid) begin
        m_dirty = 1;
      end
      if (pos_valid) begin m_px = cx; m_py = cy; end
    end
  end

  always @(negedge clk) begin
    int h, v;
    logic [3:0] ex, ey;
    h = int'(hcount);
    v = int'(vcount);
    ex = 4'd0; ey = 4'd0;
    if (in_valid && in_win(h, v)) begin
      ex = 4'((h - m_ax) & 15);
      ey = 4'((v - m_ay) & 15);
    end
    chk("out_valid", 32'(vif0.out_valid), 32'(e2.v));
    chk("rgb_out", 32'(vif0.rgb_out), 32'(e2.rgb));
    chk("cursor_hit", 32'(vif0.cursor_hit), 32'(e2.hit));
    chk("out_valid_t", 32'(vif1.out_valid), 32'(e2.v));
    chk("rgb_out_t", 32'(vif1.rgb_out), 32'(e2.rgbt));
    chk("cursor_hit_t", 32'(vif1.cursor_hit), 32'(e2.hit));
    chk("rom_x", 32'(rom_x0), 32'(ex));
    chk("rom_y", 32'(rom_y0), 32'(ey));
    chk("rom_x_t", 32'(rom_x1), 32'(ex));
    chk("rom_y_t", 32'(rom_y1), 32'(ey));
    if (e2.pe) begin
      chk("pin_rgb", 32'(vif0.rgb_out), 32'(e2.pv));
      chk("pin_rgb_t", 32'(vif1.rgb_out), 32'(e2.ptv));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = 1'b0; rgb_in = 12'hABC; frame_start = 1'b0; pos_valid = 1'b0; pin_en = 1'b0;
  endtask

  task automatic pix(int h, int v, logic [11:0] rgb);
    in_valid = 1'b1; hcount = 11'(h); vcount = 11'(v); rgb_in = rgb;
    step();
  endtask

  task automatic pin(int h, int v, logic [11:0] rgb, logic [11:0] pv, logic [11:0] ptv);
    pin_en = 1'b1; pin_val = pv; pin_tval = ptv;
    pix(h, v, rgb);
  endtask

  task automatic pin_rom(int h, int v, logic [11:0] rgb, logic [11:0] pv, logic [11:0] ptv,
                         logic [3:0] ex, logic [3:0] ey);
    in_valid = 1'b1; hcount = 11'(h); vcount = 11'(v); rgb_in = rgb;
    pin_en = 1'b1; pin_val = pv; pin_tval = ptv;
    #1;
    chk("lit_rom_x", 32'(rom_x0), 32'(ex));
    chk("lit_rom_y", 32'(rom_y0), 32'(ey));
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fstart(logic en, logic pv, int x, int y);
    frame_start = 1'b1; cursor_en = en; pos_valid = pv; pos_x = 11'(x); pos_y = 11'(y);
    step();
  endtask

  task automatic set_pos(int x, int y);
    pos_valid = 1'b1; pos_x = 11'(x); pos_y = 11'(y);
    step();
  endtask

  task automatic window(int x0, int x1, int y0, int y1, logic [11:0] rgb);
    for (int v = y0; v <= y1; v++) begin
      for (int h = x0; h <= x1; h++) pix(h, v, rgb);
      idle(2);
    end
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(vif0.out_valid), 32'd0);
    chk("reset_rgb_out", 32'(vif0.rgb_out), 32'd0);
    chk("reset_cursor_hit", 32'(vif0.cursor_hit), 32'd0);

    // Cursor disabled: lines pass through unchanged
    fstart(1'b0, 1'b0, 0, 0);
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 640; h++) pix(h, v, 12'((h * 7 + v * 131) & 12'hFFF));
      idle(3);
    end
    pin(5, 2, 12'h123, 12'h123, 12'h123);

    // Cursor at (100,50) over green
    set_pos(100, 50);
    fstart(1'b1, 1'b0, 0, 0);
    window(96, 119, 48, 67, 12'h0F0);
    pin_rom(100, 50, 12'h0F0, 12'h000, 12'h000, 4'd0, 4'd0);
    pin_rom(101, 51, 12'h0F0, 12'hFFF, 12'h0F0, 4'd1, 4'd1);
    pin_rom(114, 50, 12'h0F0, 12'h0F0, 12'h0F0, 4'd14, 4'd0);
    pin_rom(116, 50, 12'h0F0, 12'h0F0, 12'h0F0, 4'd0, 4'd0);
    pin_rom(115, 63, 12'h0F0, 12'h000, 12'h000, 4'd15, 4'd13);
    pin(100, 65, 12'h0F0, 12'h0F0, 12'h0F0);
    idle(2);

    // Mid-frame move is deferred to next frame_start
    set_pos(300, 200);
    pin(100, 50, 12'h0F0, 12'h000, 12'h000);
    pin(300, 200, 12'h0F0, 12'h0F0, 12'h0F0);
    idle(2);
    fstart(1'b1, 1'b0, 0, 0);
    pin(300, 200, 12'h0F0, 12'h000, 12'h000);
    pin(301, 201, 12'h0F0, 12'hFFF, 12'h0F0);
    pin(100, 50, 12'h0F0, 12'h0F0, 12'h0F0);
    idle(2);

    // Position coincident with frame_start applies immediately
    fstart(1'b1, 1'b1, 400, 300);
    pin(400, 300, 12'h0F0, 12'h000, 12'h000);
    pin(300, 200, 12'h0F0, 12'h0F0, 12'h0F0);
    idle(2);

    // Clamped to (639,479): only one on-screen cursor pixel, no wrap
    set_pos(700, 600);
    fstart(1'b1, 1'b0, 0, 0);
    window(620, 639, 470, 479, 12'h0F0);
    pin(639, 479, 12'h0F0, 12'h000, 12'h000);
    pin(638, 479, 12'h0F0, 12'h0F0, 12'h0F0);
    pin(0, 0, 12'h0F0, 12'h0F0, 12'h0F0);
    pin(0, 479, 12'h0F0, 12'h0F0, 12'h0F0);
    pin(639, 0, 12'h0F0, 12'h0F0, 12'h0F0);
    window(0, 20, 0, 2, 12'h0F0);

    // Reset mid-line flushes the pipeline and clears active state
    for (int h = 630; h < 636; h++) pix(h, 479, 12'h0F0);
    in_valid = 1'b1; hcount = 11'd636; vcount = 11'd479; rgb_in = 12'h0F0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_flush_out_valid", 32'(vif0.out_valid), 32'd0);
    chk("rst_flush_rgb_out", 32'(vif0.rgb_out), 32'd0);
    pin(639, 479, 12'h0F0, 12'h0F0, 12'h0F0);
    pin(0, 0, 12'h0F0, 12'h0F0, 12'h0F0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cursor_overlay.md
Name: cursor_overlay

Overview:
Per-pixel controller that sequences the 16x16 mouse-cursor bitmap ROM against the VGA raster stream and composites the cursor over the background pixel. It takes raster coordinates and background RGB from the video pipeline, plus the mouse position from the PS/2 mouse path. It drives the ROM x/y addresses and consumes the ROM's registered 2-bit pixel code. It outputs the composited pixel stream to the DAC stage with fixed latency.

Parameters:
CRD_W, 11, width of raster and position coordinates
COLOR_W, 12, RGB pixel width
H_ACTIVE, 640, active pixels per line; cursor x clamps to H_ACTIVE-1
V_ACTIVE, 480, active lines; cursor y clamps to V_ACTIVE-1
CONTOUR_COLOR, 12'h000, colour for code 01
FILL_COLOR, 12'hFFF, colour for code 10
FILL_TRANSPARENT, 0, when 1, code 10 shows the background

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
cursor_en  in  1  cursor display enable, sampled at frame_start
pos_valid  in  1  new mouse position strobe
pos_x  in  CRD_W  mouse x (top-left of bitmap)
pos_y  in  CRD_W  mouse y
frame_start  in  1  one-cycle pulse at the start of vertical blanking
in_valid  in  1  active-video pixel qualifier
hcount  in  CRD_W  raster x of the input pixel
vcount  in  CRD_W  raster y of the input pixel
rgb_in  in  COLOR_W  background pixel
rom_x  out  4  bitmap column to ROM (combinational)
rom_y  out  4  bitmap row to ROM (combinational)
rom_data  in  2  ROM pixel code, valid 1 clk after address
out_valid  out  1  output pixel qualifier
rgb_out  out  COLOR_W  composited pixel
cursor_hit  out  1  registered; rgb_out lies inside the 16x16 window

Behaviour:
- Reset: out_valid=0, rgb_out=0, cursor_hit=0, pipeline valids cleared, pending and active position=(0,0), active enable=0, pending_dirty=0. Reset mid-line flushes the pipeline; out_valid is 0 in the cycle after rst.
- Position handling:
  - pos_valid loads the pending registers after clamping: x>H_ACTIVE-1 becomes H_ACTIVE-1, same rule for y. It also sets pending_dirty.
  - On frame_start, pending position is copied to active if dirty, then dirty clears. cursor_en is always copied to active enable.
  - If pos_valid and frame_start occur in the same cycle, the new clamped value goes directly to active and dirty stays 0.
  - Active registers never change outside frame_start, so there is no tearing within a frame.
- Stage 0 (combinational):
  - dx=hcount-act_x and dy=vcount-act_y, computed unsigned in CRD_W bits.
  - hit0 = act_en & in_valid & (hcount>=act_x) & (hcount<act_x+16) & (vcount>=act_y) & (vcount<act_y+16). Comparisons use CRD_W+1 bits so act_x+16 never wraps.
  - rom_x=dx[3:0] and rom_y=dy[3:0] when hit0, otherwise 0.
- Stage 1 register: valid1, hit1, rgb1 <= in_valid, hit0, rgb_in. The ROM presents rom_data aligned to stage 1.
- Stage 2 register: out_valid<=valid1, cursor_hit<=hit1 & valid1, rgb_out<=sel.
  - sel=rgb1 if !hit1.
  - Otherwise by code: 00 gives rgb1; 01 gives CONTOUR_COLOR; 10 gives FILL_TRANSPARENT ? rgb1 : FILL_COLOR; 11 (reserved) gives rgb1.
- Latency: exactly 2 clk from in_valid/rgb_in to out_valid/rgb_out. No backpressure; one pixel per clock accepted indefinitely.
- When in_valid=0, rgb_out is 0 two cycles later and out_valid=0.
- Partially off-screen cursor (position near the clamp limit): only on-screen pixels are drawn. No wrap to line 0 or column 0.

Test Plan:
- Reset, then stream a full 640x480 frame with cursor_en=0 -> rgb_out==rgb_in delayed 2 clk on every pixel; cursor_hit never 1.
- pos=(100,50), cursor_en=1, frame_start, background 12'h0F0 -> (100,50)=12'h000; (101,51)=12'hFFF; (114,50)=12'h0F0 (code 00); (116,50)=12'h0F0 with rom_x=rom_y=0; (115,63)=12'h000.
- FILL_TRANSPARENT=1, same position -> (101,51)=12'h0F0; contour pixels are still 12'h000.
- pos_valid to (300,200) mid-frame -> remainder of the frame still draws at (100,50); after the next frame_start, draws at (300,200). pos_valid coincident with frame_start -> takes effect in that same frame.
- pos=(700,600) -> active=(639,479); pixel (639,479)=12'h000; no cursor pixels at x=0 or y=0.
- rst asserted for 1 clk mid-line with in_valid=1 -> out_valid=0 and rgb_out=0 on the next cycle; active position returns to (0,0) and enable to 0.
